alu_reservation_station: RTL
============================

Name: alu_reservation_station

Overview:
- Reservation station directly upstream of the ALU functional unit.
- Accepts renamed ALU and branch instructions from dispatch and holds them until both source operands are available.
- Snoops the CDB for outstanding operands.
- Issues the oldest ready entry to the ALU through a registered rs_valid handshake that respects the ALU's single-instruction occupancy.

Parameters:
- RS_DEPTH, 4, number of entries; must be ≥ 2.
- RS_DEPTH_WIDTH, $clog2(RS_DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  branch-mispredict flush; invalidates all entries
- dispatch_valid  in  1  new instruction offered
- dispatch_ready  out  1  space available (count < RS_DEPTH)
- src1_tag  in  `PHYSICAL_REG_NUM_WIDTH  producer physical register of operand 1
- src1_rdy  in  1  operand 1 value already valid
- src1_val  in  `REG_VAL_WIDTH  operand 1 value, meaningful when src1_rdy=1
- src2_tag / src2_rdy / src2_val  in  same widths  operand 2
- dst_reg_in  in  `PHYSICAL_REG_NUM_WIDTH  destination physical register
- control_in  in  control_t  decoded control
- immediate_in  in  `REG_VAL_WIDTH  immediate
- pc_in  in  `INST_ADDR_WIDTH  instruction PC
- tag_in  in  `ROB_SIZE_WIDTH  ROB tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_addr  in  `PHYSICAL_REG_NUM_WIDTH  broadcast physical register
- cdb_val  in  `REG_VAL_WIDTH  broadcast value
- alu_ready  in  1  ALU idle
- rs_valid  out  1  issue strobe to ALU
- src_reg1_val, src_reg2_val  out  `REG_VAL_WIDTH  issued operands
- dst_reg_addr  out  `PHYSICAL_REG_NUM_WIDTH  issued destination
- control  out  control_t  issued control
- immediate  out  `REG_VAL_WIDTH  issued immediate
- pc_out  out  `INST_ADDR_WIDTH  issued PC
- new_inst_tag_out  out  `ROB_SIZE_WIDTH  issued ROB tag

Behaviour:
- Reset (synchronous, at posedge clk while reset=1): all entries invalid, count=0, rs_valid=0, all issue outputs 0, dispatch_ready=1.
- Storage is a compacting age-ordered queue: entry 0 is the oldest. Each entry holds valid, per-operand rdy/tag/val, and the payload fields.
- dispatch_ready is combinational: count < RS_DEPTH. There is no same-cycle free-then-fill; a full queue with an issue that cycle still reports 0.
- Dispatch accepted when dispatch_valid && dispatch_ready. The new entry is written at index count after compaction for any same-cycle issue.
- CDB wakeup, every cycle, every valid entry: if cdb_valid and !srcN_rdy and srcN_tag==cdb_addr, then srcN_val<=cdb_val and srcN_rdy<=1.
- CDB at dispatch: a dispatching operand with rdy=0 whose tag matches the same-cycle CDB is captured as ready with cdb_val.
- Operand 2 is stored and tracked regardless of control_in.alu_src; no operand is skipped.
- Issue condition, evaluated at each edge: rs_valid==0 && alu_ready==1 && some valid entry has both operands ready. Select the lowest index (oldest) such entry.
- Issue outputs are registered; rs_valid is high for exactly one cycle. The issued entry is removed and younger entries shift down one slot in the same edge.
- rs_valid is never asserted on consecutive cycles. alu_ready is not sampled while rs_valid=1, which prevents a combinational loop with the ALU.
- Payload outputs hold their last issued values while rs_valid=0.
- count update: +1 on dispatch, −1 on issue, unchanged when both or neither occur.
- flush: all entries invalid, count=0, rs_valid=0 on the next edge. Dispatch and issue in the flush cycle are discarded. reset has priority over flush.
- Reset mid-operation discards all state, including a pending issue.

Optional Feature:
- Macro: RS_ISSUE_BYPASS_EN.
- With the macro defined: an entry whose last missing operand matches the CDB this cycle is eligible for issue at this edge. The operand output is taken directly from cdb_val. This also applies to a dispatching instruction when the queue is empty.
- Without the macro: an entry becomes eligible only in the cycle after its last operand is captured.

Test Plan:
- Reset, then dispatch add with src1_rdy=1 val=5, src2_rdy=1 val=7, alu_ready=1 -> one cycle after acceptance rs_valid=1, src_reg1_val=5, src_reg2_val=7, then rs_valid=0.
- Dispatch with src2_rdy=0 tag=9; CDB addr=9 val=0x20 three cycles later -> issue src_reg2_val=0x20 two edges after the CDB cycle without the macro, one edge after with it.
- Fill 4 entries, all waiting -> dispatch_ready=0. CDB wakes entries 2 and 1 in the same cycle -> entry 1 issues first, entry 2 issues no earlier than two cycles later, dispatch_ready=1 after the first issue.
- Hold alu_ready=0 for 5 cycles with 2 ready entries -> no rs_valid. alu_ready=1 -> the older entry issues, rs_valid is never high on back-to-back cycles.
- Dispatch and CDB for the same tag in one cycle -> the entry is stored ready with cdb_val.
- flush with 3 valid entries and a same-cycle dispatch -> next cycle count=0, dispatch_ready=1, rs_valid=0; a later CDB has no effect.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// Shared widths, decoded control type and the dispatch/CDB/issue bus of the ALU
// reservation station. The station is the slave; dispatch, CDB and ALU drive as master.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package alu_rs_pkg;
  typedef struct packed {
    logic       alu_src;
    logic       is_branch;
    logic [3:0] alu_op;
  } control_t;
endpackage

interface alu_reservation_station_if;
  import alu_rs_pkg::*;

  logic                               flush;
  logic                               dispatch_valid;
  logic                               dispatch_ready;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src1_tag;
  logic                               src1_rdy;
  logic [`REG_VAL_WIDTH-1:0]          src1_val;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src2_tag;
  logic                               src2_rdy;
  logic [`REG_VAL_WIDTH-1:0]          src2_val;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_in;
  control_t                           control_in;
  logic [`REG_VAL_WIDTH-1:0]          immediate_in;
  logic [`INST_ADDR_WIDTH-1:0]        pc_in;
  logic [`ROB_SIZE_WIDTH-1:0]         tag_in;
  logic                               cdb_valid;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] cdb_addr;
  logic [`REG_VAL_WIDTH-1:0]          cdb_val;
  logic                               alu_ready;
  logic                               rs_valid;
  logic [`REG_VAL_WIDTH-1:0]          src_reg1_val;
  logic [`REG_VAL_WIDTH-1:0]          src_reg2_val;
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr;
  control_t                           control;
  logic [`REG_VAL_WIDTH-1:0]          immediate;
  logic [`INST_ADDR_WIDTH-1:0]        pc_out;
  logic [`ROB_SIZE_WIDTH-1:0]         new_inst_tag_out;

  modport master (
    output flush, dispatch_valid, src1_tag, src1_rdy, src1_val,
           src2_tag, src2_rdy, src2_val, dst_reg_in, control_in,
           immediate_in, pc_in, tag_in, cdb_valid, cdb_addr, cdb_val, alu_ready,
    input  dispatch_ready, rs_valid, src_reg1_val, src_reg2_val, dst_reg_addr,
           control, immediate, pc_out, new_inst_tag_out
  );

  modport slave (
    input  flush, dispatch_valid, src1_tag, src1_rdy, src1_val,
           src2_tag, src2_rdy, src2_val, dst_reg_in, control_in,
           immediate_in, pc_in, tag_in, cdb_valid, cdb_addr, cdb_val, alu_ready,
    output dispatch_ready, rs_valid, src_reg1_val, src_reg2_val, dst_reg_addr,
           control, immediate, pc_out, new_inst_tag_out
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Compacting, age-ordered ALU reservation station with CDB wakeup and oldest-ready issue.
// Optional macro RS_ISSUE_BYPASS_EN lets an operand woken by the CDB issue in the same edge.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH       = 4,
  parameter int RS_DEPTH_WIDTH = $clog2(RS_DEPTH + 1)
) (
  input logic                      clk,
  input logic                      reset,
  alu_reservation_station_if.slave rs_if
);

  typedef struct packed {
    logic                               valid;
    logic                               src1_rdy;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src1_tag;
    logic [`REG_VAL_WIDTH-1:0]          src1_val;
    logic                               src2_rdy;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src2_tag;
    logic [`REG_VAL_WIDTH-1:0]          src2_val;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg;
    control_t                           control;
    logic [`REG_VAL_WIDTH-1:0]          immediate;
    logic [`INST_ADDR_WIDTH-1:0]        pc;
    logic [`ROB_SIZE_WIDTH-1:0]         rob_tag;
  } rs_entry_t;

  typedef struct packed {
    logic [`REG_VAL_WIDTH-1:0]          src1_val;
    logic [`REG_VAL_WIDTH-1:0]          src2_val;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg;
    control_t                           control;
    logic [`REG_VAL_WIDTH-1:0]          immediate;
    logic [`INST_ADDR_WIDTH-1:0]        pc;
    logic [`ROB_SIZE_WIDTH-1:0]         rob_tag;
  } issue_t;

  function automatic issue_t to_issue(input rs_entry_t e);
    issue_t r;
    r.src1_val  = e.src1_val;
    r.src2_val  = e.src2_val;
    r.dst_reg   = e.dst_reg;
    r.control   = e.control;
    r.immediate = e.immediate;
    r.pc        = e.pc;
    r.rob_tag   = e.rob_tag;
    return r;
  endfunction

  rs_entry_t                 entries_q [RS_DEPTH];
  rs_entry_t                 entries_d [RS_DEPTH];
  rs_entry_t                 woken     [RS_DEPTH+1];
  rs_entry_t                 new_entry;
  rs_entry_t                 sel_entry;
  logic [RS_DEPTH_WIDTH-1:0] count_q, count_d, wr_idx;
  logic                      rs_valid_q, rs_valid_d;
  issue_t                    issue_q, issue_d;
  logic [RS_DEPTH-1:0]       elig;
  logic                      found;
  int                        sel_idx;
  logic                      cap1, cap2;
  logic                      dispatch_ready;
  logic                      disp_fire, issue_window, issue_from_q, issue_direct, store_new;

  assign dispatch_ready = count_q < RS_DEPTH_WIDTH'(RS_DEPTH);

  // Queue contents as they look after this cycle's CDB broadcast; the extra
  // all-zero slot feeds the top entry during compaction.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      woken[i] = entries_q[i];
      if (rs_if.cdb_valid && entries_q[i].valid) begin
        if (!entries_q[i].src1_rdy && (entries_q[i].src1_tag == rs_if.cdb_addr)) begin
          woken[i].src1_rdy = 1'b1;
          woken[i].src1_val = rs_if.cdb_val;
        end
        if (!entries_q[i].src2_rdy && (entries_q[i].src2_tag == rs_if.cdb_addr)) begin
          woken[i].src2_rdy = 1'b1;
          woken[i].src2_val = rs_if.cdb_val;
        end
      end
    end
    woken[RS_DEPTH] = '0;
  end

  always_comb begin
    cap1 = rs_if.cdb_valid && !rs_if.src1_rdy && (rs_if.src1_tag == rs_if.cdb_addr);
    cap2 = rs_if.cdb_valid && !rs_if.src2_rdy && (rs_if.src2_tag == rs_if.cdb_addr);
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.src1_rdy  = rs_if.src1_rdy || cap1;
    new_entry.src1_tag  = rs_if.src1_tag;
    new_entry.src1_val  = cap1 ? rs_if.cdb_val : rs_if.src1_val;
    new_entry.src2_rdy  = rs_if.src2_rdy || cap2;
    new_entry.src2_tag  = rs_if.src2_tag;
    new_entry.src2_val  = cap2 ? rs_if.cdb_val : rs_if.src2_val;
    new_entry.dst_reg   = rs_if.dst_reg_in;
    new_entry.control   = rs_if.control_in;
    new_entry.immediate = rs_if.immediate_in;
    new_entry.pc        = rs_if.pc_in;
    new_entry.rob_tag   = rs_if.tag_in;
  end

  // Oldest-first pick; without the bypass an entry only counts as ready once
  // its operands are already held in the queue.
  always_comb begin
    found     = 1'b0;
    sel_idx   = 0;
    sel_entry = woken[0];
    for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_ISSUE_BYPASS_EN
      elig[i] = woken[i].valid && woken[i].src1_rdy && woken[i].src2_rdy;
`else
      elig[i] = entries_q[i].valid && entries_q[i].src1_rdy && entries_q[i].src2_rdy;
`endif
      if (!found && elig[i]) begin
        found     = 1'b1;
        sel_idx   = i;
        sel_entry = woken[i];
      end
    end
  end

  always_comb begin
    disp_fire    = rs_if.dispatch_valid && dispatch_ready;
    issue_window = !rs_valid_q && rs_if.alu_ready;
    issue_from_q = issue_window && found;
`ifdef RS_ISSUE_BYPASS_EN
    issue_direct = issue_window && !found && disp_fire && (count_q == '0) &&
                   new_entry.src1_rdy && new_entry.src2_rdy && (cap1 || cap2);
`else
    issue_direct = 1'b0;
`endif
    store_new  = disp_fire && !issue_direct;
    wr_idx     = count_q - RS_DEPTH_WIDTH'(issue_from_q);
    count_d    = count_q + RS_DEPTH_WIDTH'(store_new) - RS_DEPTH_WIDTH'(issue_from_q);
    rs_valid_d = issue_from_q || issue_direct;
    issue_d    = issue_q;
    if (issue_from_q) begin
      issue_d = to_issue(sel_entry);
    end else if (issue_direct) begin
      issue_d = to_issue(new_entry);
    end

    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_d[i] = (issue_from_q && (i >= sel_idx)) ? woken[i+1] : woken[i];
      if (store_new && (i == int'(wr_idx))) begin
        entries_d[i] = new_entry;
      end
    end

    if (rs_if.flush) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_d[i] = '0;
      end
      count_d    = '0;
      rs_valid_d = 1'b0;
      issue_d    = issue_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q    <= '0;
      rs_valid_q <= 1'b0;
      issue_q    <= '0;
    end else begin
      entries_q  <= entries_d;
      count_q    <= count_d;
      rs_valid_q <= rs_valid_d;
      issue_q    <= issue_d;
    end
  end

  assign rs_if.dispatch_ready   = dispatch_ready;
  assign rs_if.rs_valid         = rs_valid_q;
  assign rs_if.src_reg1_val     = issue_q.src1_val;
  assign rs_if.src_reg2_val     = issue_q.src2_val;
  assign rs_if.dst_reg_addr     = issue_q.dst_reg;
  assign rs_if.control          = issue_q.control;
  assign rs_if.immediate        = issue_q.immediate;
  assign rs_if.pc_out           = issue_q.pc;
  assign rs_if.new_inst_tag_out = issue_q.rob_tag;

endmodule
